uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// UART transmitter with a transmit FIFO in front of it.
// Frame: start bit, DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_uart,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 overflow,
  output logic [2:0]           state_dbg
);

  // Handshake: wr_uart is a strobe with no ready. A write sampled while
  // fifo_full=1 is dropped and reported by a one-cycle overflow pulse.

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [17:0] BIT_END  = 18'(CLKS_PER_BIT - 1);
  localparam logic [17:0] STOP_END = 18'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [3:0]  LAST_BIT = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  state_t               state, state_next;
  logic [17:0]          baud, baud_next;
  logic [3:0]           bit_idx, bit_next;
  logic [DATA_BITS-1:0] shreg, shreg_next;
  logic                 par_bit, par_next;
  logic                 tx_next;
  logic                 done_next;

  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign push       = wr_uart && !fifo_full;
  assign head       = mem[rd_ptr];
  assign tx_busy    = (state != S_IDLE);
  assign state_dbg  = state;

  always_ff @(posedge clk) begin
    if (push && !reset) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      // Fullness is judged on the pre-edge count, so a same-cycle pop does not rescue the write.
      overflow <= wr_uart && fifo_full;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tx      <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      state   <= state_next;
      baud    <= baud_next;
      bit_idx <= bit_next;
      shreg   <= shreg_next;
      par_bit <= par_next;
      tx      <= tx_next;
      tx_done <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    baud_next  = baud + 18'd1;
    bit_next   = bit_idx;
    shreg_next = shreg;
    par_next   = par_bit;
    tx_next    = tx;
    done_next  = 1'b0;
    pop        = 1'b0;
    unique case (state)
      S_IDLE: begin
        baud_next = '0;
        tx_next   = 1'b1;
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = S_START;
          tx_next    = 1'b0;
        end
      end
      S_START: begin
        if (baud == BIT_END) begin
          state_next = S_DATA;
          baud_next  = '0;
          bit_next   = '0;
          tx_next    = shreg[0];
        end
      end
      S_DATA: begin
        if (baud == BIT_END) begin
          baud_next = '0;
          if (bit_idx == LAST_BIT) begin
            if (PARITY != 0) begin
              state_next = S_PARITY;
              tx_next    = par_bit;
            end else begin
              state_next = S_STOP;
              tx_next    = 1'b1;
            end
          end else begin
            bit_next   = bit_idx + 4'd1;
            shreg_next = shreg >> 1;
            tx_next    = shreg[1];
          end
        end
      end
      S_PARITY: begin
        if (baud == BIT_END) begin
          state_next = S_STOP;
          baud_next  = '0;
          tx_next    = 1'b1;
        end
      end
      S_STOP: begin
        if (baud == STOP_END) begin
          done_next = 1'b1;
          baud_next = '0;
          // Chain straight into the next frame when a word is waiting.
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = S_START;
            tx_next    = 1'b0;
          end else begin
            state_next = S_IDLE;
            tx_next    = 1'b1;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        baud_next  = '0;
        tx_next    = 1'b1;
      end
    endcase
    if (pop) begin
      shreg_next = head;
      baud_next  = '0;
      bit_next   = '0;
      par_next   = (^head) ^ (PARITY == 1);
    end
  end

endmodule
